// File: rtl/palette_arb_pkg.sv
//------------------------------------------------------------------------------
// palette_arb_pkg
// Shared types and constants for the palette read arbiter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package palette_arb_pkg;

  typedef logic [0:0] req_id_t;

  localparam req_id_t REQ_SCANOUT      = 1'b0;
  localparam req_id_t REQ_CPU          = 1'b1;
  localparam int      MAX_PENDING_DFLT = 8;

endpackage

`default_nettype wire

// File: rtl/palette_arb_tag_fifo.sv
//------------------------------------------------------------------------------
// palette_arb_tag_fifo
// In-order store of requester IDs for reads awaiting a palette response.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module palette_arb_tag_fifo
  import palette_arb_pkg::*;
#(
  parameter  int DEPTH = MAX_PENDING_DFLT,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  req_id_t          i_push_id,
  input  logic             i_pop,
  output req_id_t          o_head_id,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  req_id_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers wrap naturally because DEPTH is a power of two; the count
  // alone tells full from empty.
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head_id = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_id;
  end

endmodule

`default_nettype wire

// File: rtl/palette_read_arbiter.sv
//------------------------------------------------------------------------------
// palette_read_arbiter
// Two-requester read arbiter in front of a pipelined palette lookup slave.
// Define PALETTE_ARB_RR_EN for round-robin; default is fixed priority (r0).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module palette_read_arbiter
  import palette_arb_pkg::*;
#(
  parameter  int MAX_PENDING = MAX_PENDING_DFLT,
  parameter  int ADDR_W      = 24,
  localparam int CNT_W       = $clog2(MAX_PENDING) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              avs_r0_read,
  input  logic [ADDR_W-1:0] avs_r0_address,
  output logic              avs_r0_waitrequest,
  output logic [31:0]       avs_r0_readdata,
  output logic              avs_r0_readdatavalid,
  input  logic              avs_r1_read,
  input  logic [ADDR_W-1:0] avs_r1_address,
  output logic              avs_r1_waitrequest,
  output logic [31:0]       avs_r1_readdata,
  output logic              avs_r1_readdatavalid,
  output logic              avm_read,
  output logic [ADDR_W-1:0] avm_address,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [CNT_W-1:0]  pending_count,
  output logic              err_orphan
);

  req_id_t     w_gnt;
  logic        w_gnt_req;
  logic        w_issue;
  logic        w_accept;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  req_id_t     w_head_id;
  logic        r_locked;
  req_id_t     r_lock_id;
  logic        r_r0_rdv;
  logic        r_r1_rdv;
  logic [31:0] r_r0_rdata;
  logic [31:0] r_r1_rdata;
  logic        r_err_orphan;

`ifdef PALETTE_ARB_RR_EN
  req_id_t     r_rr_prio;

  // Priority goes to whichever requester was not accepted last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_rr_prio <= REQ_SCANOUT;
    else if (w_accept) r_rr_prio <= ~w_gnt;
  end
`endif

  always_comb begin
    w_gnt = REQ_SCANOUT;
    if (r_locked) begin
      w_gnt = r_lock_id;
    end else if (avs_r0_read && avs_r1_read) begin
`ifdef PALETTE_ARB_RR_EN
      w_gnt = r_rr_prio;
`else
      w_gnt = REQ_SCANOUT;
`endif
    end else if (avs_r1_read) begin
      w_gnt = REQ_CPU;
    end
  end

  // Reset gates the combinational master side so nothing escapes while held.
  assign w_gnt_req   = (w_gnt == REQ_CPU) ? avs_r1_read : avs_r0_read;
  assign w_issue     = w_gnt_req & ~w_full & ~reset;
  assign w_accept    = w_issue & ~avm_waitrequest;
  assign w_pop       = avm_readdatavalid & ~w_empty;
  assign avm_read    = w_issue;
  assign avm_address = !w_issue ? '0 :
                       (w_gnt == REQ_CPU) ? avs_r1_address : avs_r0_address;

  assign avs_r0_waitrequest = ~(w_accept && (w_gnt == REQ_SCANOUT));
  assign avs_r1_waitrequest = ~(w_accept && (w_gnt == REQ_CPU));

  palette_arb_tag_fifo #(
    .DEPTH (MAX_PENDING)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (reset),
    .i_push    (w_accept),
    .i_push_id (w_gnt),
    .i_pop     (w_pop),
    .o_head_id (w_head_id),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (pending_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_locked     <= 1'b0;
      r_lock_id    <= REQ_SCANOUT;
      r_r0_rdv     <= 1'b0;
      r_r1_rdv     <= 1'b0;
      r_r0_rdata   <= '0;
      r_r1_rdata   <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      // A stalled issue freezes the grant until the slave takes it.
      r_locked  <= w_issue & avm_waitrequest;
      r_lock_id <= w_gnt;
      r_r0_rdv  <= w_pop && (w_head_id == REQ_SCANOUT);
      r_r1_rdv  <= w_pop && (w_head_id == REQ_CPU);
      if (w_pop && (w_head_id == REQ_SCANOUT)) r_r0_rdata <= avm_readdata;
      if (w_pop && (w_head_id == REQ_CPU))     r_r1_rdata <= avm_readdata;
      if (avm_readdatavalid && w_empty)        r_err_orphan <= 1'b1;
    end
  end

  assign avs_r0_readdatavalid = r_r0_rdv;
  assign avs_r1_readdatavalid = r_r1_rdv;
  assign avs_r0_readdata      = r_r0_rdata;
  assign avs_r1_readdata      = r_r1_rdata;
  assign err_orphan           = r_err_orphan;

endmodule

`default_nettype wire

// File: tb/tb_palette_read_arbiter.sv
//------------------------------------------------------------------------------
// tb_palette_read_arbiter
// Self-checking bench for palette_read_arbiter (table plus directed sequences).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_palette_read_arbiter;

  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          r0_read, r1_read, r0_wr, r1_wr, r0_rdv, r1_rdv;
  logic [AW-1:0] r0_addr, r1_addr, m_addr;
  logic [31:0]   r0_rdata, r1_rdata, m_rdata;
  logic          m_read, m_wr, m_rdv, orphan;
  logic [3:0]    pcount;

  always #5 clk = ~clk;

  palette_read_arbiter dut (
    .clk                  (clk),
    .reset                (reset),
    .avs_r0_read          (r0_read),
    .avs_r0_address       (r0_addr),
    .avs_r0_waitrequest   (r0_wr),
    .avs_r0_readdata      (r0_rdata),
    .avs_r0_readdatavalid (r0_rdv),
    .avs_r1_read          (r1_read),
    .avs_r1_address       (r1_addr),
    .avs_r1_waitrequest   (r1_wr),
    .avs_r1_readdata      (r1_rdata),
    .avs_r1_readdatavalid (r1_rdv),
    .avm_read             (m_read),
    .avm_address          (m_addr),
    .avm_waitrequest      (m_wr),
    .avm_readdata         (m_rdata),
    .avm_readdatavalid    (m_rdv),
    .pending_count        (pcount),
    .err_orphan           (orphan)
  );

  typedef struct {
    logic          tid;
    logic [31:0]   data;
  } resp_t;

  typedef struct {
    logic          r0;
    logic          r1;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic          wr;
    logic          rdv;
    logic [31:0]   d;
    int            gfx;
    int            grr;
  } vec_t;

  int          n_total = 0;
  int          n_bad   = 0;
  logic        tag_q[$];
  resp_t       resp_q[$];
  logic [31:0] last0, last1;
  logic        exp_orph;
  vec_t        tv[15];

  task automatic chk(input string tag, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s %s: got %0h want %0h", tag, name, act, exp);
    end
  endtask

  // One clock of stimulus; exp_g is the requester the bench expects granted (2 = none).
  task automatic cycle(input string tag, input logic r0, input logic [AW-1:0] a0,
                       input logic r1, input logic [AW-1:0] a1, input logic wr,
                       input logic rdv, input logic [31:0] d, input int exp_g);
    logic  acc, popv, ev0, ev1;
    resp_t e;
    r0_read = r0; r0_addr = a0; r1_read = r1; r1_addr = a1;
    m_wr = wr; m_rdv = rdv; m_rdata = d;
    #1;
    chk(tag, "avm_read", 32'(m_read), 32'(exp_g != 2));
    chk(tag, "avm_address", 32'(m_addr),
        (exp_g == 0) ? 32'(a0) : (exp_g == 1) ? 32'(a1) : 32'h0);
    chk(tag, "r0_waitrequest", 32'(r0_wr), 32'(!(exp_g == 0 && !wr)));
    chk(tag, "r1_waitrequest", 32'(r1_wr), 32'(!(exp_g == 1 && !wr)));
    acc  = (exp_g != 2) && !wr;
    popv = rdv && (tag_q.size() > 0);
    if (popv) resp_q.push_back('{tid: tag_q.pop_front(), data: d});
    else if (rdv) exp_orph = 1'b1;
    if (acc) tag_q.push_back(exp_g[0]);
    @(posedge clk);
    #1;
    ev0 = 1'b0; ev1 = 1'b0;
    if (popv) begin
      e = resp_q.pop_front();
      if (e.tid) begin ev1 = 1'b1; last1 = e.data; end
      else       begin ev0 = 1'b1; last0 = e.data; end
    end
    chk(tag, "pending_count", 32'(pcount), 32'(tag_q.size()));
    chk(tag, "r0_readdatavalid", 32'(r0_rdv), 32'(ev0));
    chk(tag, "r1_readdatavalid", 32'(r1_rdv), 32'(ev1));
    chk(tag, "r0_readdata", r0_rdata, last0);
    chk(tag, "r1_readdata", r1_rdata, last1);
    chk(tag, "err_orphan", 32'(orphan), 32'(exp_orph));
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    r0_read = 1'b1; r0_addr = 24'h00ABCD; r1_read = 1'b1; r1_addr = 24'h00DCBA;
    m_wr = 1'b0; m_rdv = 1'b0; m_rdata = '0;
    #1;
    chk(tag, "rst avm_read", 32'(m_read), 32'h0);
    chk(tag, "rst avm_address", 32'(m_addr), 32'h0);
    chk(tag, "rst r0_waitrequest", 32'(r0_wr), 32'h1);
    chk(tag, "rst r1_waitrequest", 32'(r1_wr), 32'h1);
    @(posedge clk);
    #1;
    chk(tag, "rst r0_readdatavalid", 32'(r0_rdv), 32'h0);
    chk(tag, "rst r1_readdatavalid", 32'(r1_rdv), 32'h0);
    chk(tag, "rst r0_readdata", r0_rdata, 32'h0);
    chk(tag, "rst r1_readdata", r1_rdata, 32'h0);
    chk(tag, "rst pending_count", 32'(pcount), 32'h0);
    chk(tag, "rst err_orphan", 32'(orphan), 32'h0);
    tag_q.delete(); resp_q.delete();
    last0 = '0; last1 = '0; exp_orph = 1'b0;
    reset = 1'b0;
    r0_read = 1'b0; r1_read = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int g;
    reset = 1'b1;
    do_reset("init");

    tv[0]  = '{1'b1, 1'b0, 24'h000010, 24'h000000, 1'b0, 1'b0, 32'h0, 0, 0};
    tv[1]  = '{1'b1, 1'b1, 24'h000020, 24'h000120, 1'b0, 1'b0, 32'h0, 0, 1};
    tv[2]  = '{1'b1, 1'b1, 24'h000030, 24'h000130, 1'b0, 1'b0, 32'h0, 0, 0};
    tv[3]  = '{1'b1, 1'b1, 24'h000040, 24'h000140, 1'b0, 1'b1, 32'h12345678, 0, 1};
    tv[4]  = '{1'b0, 1'b1, 24'h000000, 24'h000150, 1'b1, 1'b0, 32'h0, 1, 1};
    tv[5]  = '{1'b1, 1'b1, 24'h000060, 24'h000150, 1'b1, 1'b0, 32'h0, 1, 1};
    tv[6]  = '{1'b1, 1'b1, 24'h000060, 24'h000150, 1'b1, 1'b0, 32'h0, 1, 1};
    tv[7]  = '{1'b1, 1'b1, 24'h000060, 24'h000150, 1'b0, 1'b0, 32'h0, 1, 1};
    tv[8]  = '{1'b1, 1'b0, 24'h000070, 24'h000000, 1'b0, 1'b0, 32'h0, 0, 0};
    for (int i = 9; i < 14; i++)
      tv[i] = '{1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 1'b1, 32'hD0000000 + 32'(i), 2, 2};
    tv[14] = '{1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 1'b0, 32'h0, 2, 2};

    for (int i = 0; i < 15; i++) begin
`ifdef PALETTE_ARB_RR_EN
      g = tv[i].grr;
`else
      g = tv[i].gfx;
`endif
      cycle($sformatf("vec%0d", i), tv[i].r0, tv[i].a0, tv[i].r1, tv[i].a1,
            tv[i].wr, tv[i].rdv, tv[i].d, g);
    end

    // Single scanout read, response three cycles later.
    cycle("basic_req", 1'b1, 24'h000010, 1'b0, 24'h0, 1'b0, 1'b0, 32'h0, 0);
    for (int i = 0; i < 3; i++)
      cycle("basic_wait", 1'b0, 24'h0, 1'b0, 24'h0, 1'b0, 1'b0, 32'h0, 2);
    cycle("basic_rsp", 1'b0, 24'h0, 1'b0, 24'h0, 1'b0, 1'b1, 32'h0000FFFF, 2);
    cycle("basic_idle", 1'b0, 24'h0, 1'b0, 24'h0, 1'b0, 1'b0, 32'h0, 2);

    // Fill the tag FIFO, then free one slot.
    for (int i = 0; i < 8; i++)
      cycle($sformatf("fill%0d", i), 1'b0, 24'h0, 1'b1, 24'h000200 + 24'(i),
            1'b0, 1'b0, 32'h0, 1);
    cycle("full_block", 1'b1, 24'h000300, 1'b1, 24'h000301, 1'b0, 1'b0, 32'h0, 2);
    cycle("full_rsp", 1'b1, 24'h000300, 1'b1, 24'h000301, 1'b0, 1'b1, 32'hA5A50001, 2);
    cycle("after_full", 1'b1, 24'h000300, 1'b1, 24'h000301, 1'b0, 1'b0, 32'h0, 0);
    for (int i = 0; i < 8; i++)
      cycle($sformatf("drain%0d", i), 1'b0, 24'h0, 1'b0, 24'h0, 1'b0, 1'b1,
            32'hB0000000 + 32'(i), 2);

    // Orphan response with nothing pending.
    cycle("orphan_idle", 1'b0, 24'h0, 1'b0, 24'h0, 1'b0, 1'b1, 32'hDEAD0001, 2);
    cycle("orphan_sticky", 1'b0, 24'h0, 1'b0, 24'h0, 1'b0, 1'b0, 32'h0, 2);
    do_reset("orphan_clear");

    // Reset with reads in flight: later responses are orphans.
    cycle("mid_r0", 1'b1, 24'h000400, 1'b0, 24'h0, 1'b0, 1'b0, 32'h0, 0);
    cycle("mid_r1", 1'b0, 24'h0, 1'b1, 24'h000401, 1'b0, 1'b0, 32'h0, 1);
    do_reset("mid_reset");
    cycle("mid_orphan", 1'b0, 24'h0, 1'b0, 24'h0, 1'b0, 1'b1, 32'hDEAD0002, 2);
    do_reset("final");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/palette_read_arbiter.md
PALETTE_READ_ARBITER -- requirements
Module: palette_read_arbiter

Interface
REQ-001 Parameter MAX_PENDING, default 8, shall set the maximum outstanding reads; power of two, 2..32.
REQ-002 Parameter ADDR_W, default 24, shall set the address width on all ports.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 avs_r0_read / avs_r0_address  input  1 / ADDR_W  requester 0 (scanout) read request and address.
REQ-006 avs_r0_waitrequest  output  1  requester 0 stall.
REQ-007 avs_r0_readdata / avs_r0_readdatavalid  output  32 / 1  requester 0 response (two palette pixels).
REQ-008 avs_r1_* shall be identical to REQ-005..007 for requester 1 (CPU readback).
REQ-009 avm_read / avm_address  output  1 / ADDR_W  request to the palette lookup slave.
REQ-010 avm_waitrequest  input  1  palette slave stall.
REQ-011 avm_readdata / avm_readdatavalid  input  32 / 1  palette slave response, in issue order.
REQ-012 pending_count  output  $clog2(MAX_PENDING)+1  reads issued but not yet returned.
REQ-013 err_orphan  output  1  sticky: a response arrived with no read pending.

Function
REQ-014 Grant selection shall be combinational among requesters with read asserted; avm_read/avm_address shall mirror the granted requester in the same cycle.
REQ-015 A read is accepted on an edge where avm_read=1 and avm_waitrequest=0; the granted requester's waitrequest shall equal avm_waitrequest OR tag-FIFO full.
REQ-016 A non-granted requester with read asserted shall see waitrequest=1; with read deasserted, waitrequest is don't-care but driven 1.
REQ-017 Grant lock: once avm_read is asserted and stalled, the grant shall not change until acceptance, even if the other requester has priority.
REQ-018 On acceptance the requester ID shall be pushed to the tag FIFO; pending_count increments.
REQ-019 Tag FIFO full (pending_count=MAX_PENDING): avm_read=0, both waitrequests 1.
REQ-020 On avm_readdatavalid=1 the head tag shall be popped; readdata and readdatavalid shall appear registered on the tagged requester one cycle later; the other requester's readdatavalid stays 0.
REQ-021 Simultaneous accept and response in one cycle shall push and pop; pending_count unchanged.
REQ-022 avm_readdatavalid with pending_count=0 shall be dropped (no requester valid) and set err_orphan; pending_count stays 0 (no underflow).
REQ-023 FIFO pointers shall wrap modulo MAX_PENDING; full and empty distinguished by pending_count.
REQ-024 readdata on a requester shall hold its last value when its readdatavalid is 0.

Reset
REQ-025 While reset is high: avm_read=0, avm_address=0, both waitrequests=1, both readdatavalids=0, readdata=0, pending_count=0, err_orphan=0, round-robin pointer favours requester 0.
REQ-026 Reset mid-operation shall discard all pending tags; responses arriving afterwards are orphans per REQ-022.

Configuration
REQ-027 Macro PALETTE_ARB_RR_EN defined: round-robin; the requester not accepted most recently wins when both request; pointer updates only on acceptance.
REQ-028 PALETTE_ARB_RR_EN undefined: fixed priority, requester 0 always wins; grant lock (REQ-017) still applies.

Structure
REQ-029 Package palette_arb_pkg shall hold typedef req_id_t (1 bit), constants REQ_SCANOUT=0, REQ_CPU=1, and the default MAX_PENDING.
REQ-030 Tag storage shall be sub-module palette_arb_tag_fifo (push/pop/full/empty/count, depth MAX_PENDING).

Verification
REQ-031 r0 reads 0x000010, slave returns 0x0000FFFF 3 cycles later -> r0 readdatavalid one cycle after, readdata 0x0000FFFF; r1 valid stays 0.
REQ-032 RR_EN: both request continuously, no stalls -> addresses alternate r0,r1,r0,r1; fixed mode -> r0 only while it requests.
REQ-033 r1 granted, avm_waitrequest high 4 cycles, r0 raises read meanwhile -> avm_address stays r1's until acceptance.
REQ-034 Issue 8 reads with no responses -> pending_count=8, avm_read=0, both waitrequests 1; one response -> count 7, next read accepted.
REQ-035 Response with pending_count=0 -> err_orphan=1, no readdatavalid; assert reset -> err_orphan=0, pending_count=0.
REQ-036 Accept and response on same edge at count 3 -> count stays 3, response routed to the FIFO-head requester.
